sfft_band_peak_finder: RTL
==========================

Name: sfft_band_peak_finder

Overview:
- Sits directly downstream of the SFFT pipeline output stage.
- Snapshots the NFFT real-valued bins when the pipeline's one-cycle output-valid pulse arrives.
- Scans the positive-frequency half (bins 0..NFFT/2-1) one bin per clock, split into NUM_BANDS equal bands.
- Emits one record per band (peak bin index, magnitude, band, frame id) over a valid/ready stream to the fingerprint/hash logic.

Parameters:
- NFFT, 512, FFT length; power of two.
- NFFT_LOG2, 9, log2(NFFT).
- DATA_WIDTH, 24, signed bin width; equals SFFT output width.
- NUM_BANDS, 8, bands per frame; power of two dividing NFFT/2.
- SKIP_DC, 1, when 1 bin 0 magnitude is forced to 0.
- DROP_CNT_WIDTH, 8, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- SFFT_In  in  DATA_WIDTH x NFFT  signed real bins from the SFFT pipeline.
- InputValid  in  1  one-cycle pulse; SFFT_In is valid in that cycle.
- peak_valid  out  1  record valid.
- peak_ready  in  1  consumer accepts the record.
- peak_bin  out  NFFT_LOG2-1  absolute bin index of the band peak.
- peak_mag  out  DATA_WIDTH  unsigned magnitude of the peak.
- peak_band  out  log2(NUM_BANDS)  band number.
- peak_frame  out  8  frame id.
- peak_last  out  1  high on the record of the last band.
- busy  out  1  high when not IDLE.
- frames_dropped  out  DROP_CNT_WIDTH  saturating count of rejected frames.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset: state IDLE; peak_valid, peak_last and busy = 0; frame counter and frames_dropped = 0; bin index and running max = 0; snapshot RAM is not cleared.
- Reset takes priority from any state. Reset mid-scan or mid-emit abandons the frame and outputs no further records.
- Derived constant: B = NFFT/(2*NUM_BANDS) bins per band.
- States:
  - IDLE: InputValid → copy SFFT_In[0..NFFT/2-1] into snapshot; clear running max; bin index = 0; go to SCAN.
  - SCAN: each cycle read snapshot[idx] and compute mag = |x| (two's complement; most-negative maps to 2^(DATA_WIDTH-1), exact in DATA_WIDTH unsigned bits).
    - If mag > runmax (strict): update runmax and runidx. Ties keep the lower index.
    - Bin 0 uses mag 0 when SKIP_DC=1.
    - When idx is the last bin of the band: register the record, go to EMIT, and seed the next band's max at 0.
  - EMIT: hold peak_valid=1 with stable outputs until peak_ready.
    - On accept, if not the last band: go to SCAN for the next band.
    - On accept of the last band: go to IDLE.
- Latency: InputValid in cycle 0 → first peak_valid in cycle B+1 (with peak_ready held high). Band n record appears at cycle (n+1)(B+1).
- Backpressure: records are never overwritten or dropped while peak_valid is high.
- Frame accept rule: InputValid is accepted only in IDLE, or in EMIT on the last band in the same cycle peak_ready=1. The latter gives a back-to-back restart straight to SCAN.
- Otherwise InputValid is ignored: snapshot unchanged, frames_dropped += 1, saturating at all-ones.
- peak_frame: increments (mod 256) on each accepted frame. The first frame after reset carries 0.
- busy = (state != IDLE).

Decomposition:
- Shared package sfft_peak_pkg holds:
  - state enum {IDLE, SCAN, EMIT};
  - peak record struct (bin, mag, band, frame, last);
  - localparams B and band-index width.
- Sub-module sfft_band_max holds abs/compare/running-max:
  - inputs: clear, en, sample, idx;
  - outputs: max, maxidx.

Test Plan (NFFT=16, NUM_BANDS=2, B=4, DATA_WIDTH=16, SKIP_DC=1):
- Basic: bins 0..7 = {100, 3, -9, 5, 2, 7, -7, 1}, peak_ready=1. Expect record 0 = bin 2, mag 9, band 0, frame 0, last 0 at cycle 5. Expect record 1 = bin 5, mag 7, band 1, last 1 at cycle 10. busy falls after acceptance.
- Tie and most-negative: band 1 = {-32768, 32767, -32768, 0}. Expect bin 4, mag 32768.
- Backpressure: peak_ready=0 for 6 cycles after record 0 appears. Outputs stay stable, no scan progress; record 1 arrives B+1 cycles after the accept.
- Drop: second InputValid 3 cycles after the first → frames_dropped=1 and first frame's records unchanged. Back-to-back InputValid coinciding with last-band accept → accepted, peak_frame=1.
- Reset mid-SCAN in cycle 2: no peak_valid follows, busy=0, frames_dropped=0. A new frame afterwards reports frame 0.
- All-zero frame: each band reports its first bin, with bin 0's band reporting bin 0 and mag 0.

Source files
------------

// File: rtl/sfft_band_peak_finder_pkg.sv
// ---------------------------------------------------------------------------
// sfft_peak_pkg
//   Shared declarations for the SFFT band peak finder:
//     - peakState_e : controller states (IDLE / SCAN / EMIT)
//     - binsPerBand / bandIdxWidth : geometry helpers used to size the
//       top-level ports and counters from its parameters
//     - DEF_* localparams and peakRec_t : the record layout at the default
//       configuration (NFFT=512, DATA_WIDTH=24, NUM_BANDS=8), for consumers
//       that want a single packed view of one emitted record
// ---------------------------------------------------------------------------
package sfft_peak_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } peakState_e;

  // Bins per band over the positive-frequency half of the spectrum.
  function automatic int unsigned binsPerBand(input int unsigned nfft,
                                              input int unsigned numBands);
    return nfft / (2 * numBands);
  endfunction

  // A single band still needs a 1-bit band field.
  function automatic int unsigned bandIdxWidth(input int unsigned numBands);
    return (numBands > 1) ? $clog2(numBands) : 1;
  endfunction

  localparam int unsigned DEF_NFFT       = 512;
  localparam int unsigned DEF_NFFT_LOG2  = 9;
  localparam int unsigned DEF_DATA_WIDTH = 24;
  localparam int unsigned DEF_NUM_BANDS  = 8;
  localparam int unsigned DEF_B          = binsPerBand(DEF_NFFT, DEF_NUM_BANDS);
  localparam int unsigned DEF_BAND_W     = bandIdxWidth(DEF_NUM_BANDS);

  typedef struct packed {
    logic [DEF_NFFT_LOG2-2:0]  bin;
    logic [DEF_DATA_WIDTH-1:0] mag;
    logic [DEF_BAND_W-1:0]     band;
    logic [7:0]                frame;
    logic                      last;
  } peakRec_t;

endpackage

// File: rtl/sfft_band_peak_finder_band_max.sv
// ---------------------------------------------------------------------------
// sfft_band_max
//   Magnitude and running-maximum tracker for one band scan.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     clear       : restart tracking (takes effect on the next sample)
//     en          : sample/idx are a valid bin this cycle
//     sample      : signed bin value
//     idx         : absolute bin index of sample
//     max, maxidx : band maximum and its index, including the current
//                   sample when en is high (combinational view)
// ---------------------------------------------------------------------------
module sfft_band_max #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned SKIP_DC    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic [DATA_WIDTH-1:0] max,
  output logic [IDX_WIDTH-1:0]  maxidx
);

  logic [DATA_WIDTH-1:0] runMax;
  logic [IDX_WIDTH-1:0]  runIdx;
  logic                  empty;
  logic [DATA_WIDTH-1:0] mag;
  logic                  take;

  always_comb begin
    // Two's complement negate in DATA_WIDTH bits: the most-negative value
    // maps onto 2^(DATA_WIDTH-1), which is still exact as unsigned.
    mag = sample[DATA_WIDTH-1] ? (~sample + DATA_WIDTH'(1)) : sample;
    if (SKIP_DC != 0 && idx == '0) begin
      mag = '0;
    end
    // The first bin of a band is always taken so an all-zero band reports
    // its own first bin; afterwards strictly-greater keeps the lower index.
    take   = en && (empty || (mag > runMax));
    max    = take ? mag : runMax;
    maxidx = take ? idx : runIdx;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      runMax <= '0;
      runIdx <= '0;
      empty  <= 1'b1;
    end else if (en) begin
      runMax <= max;
      runIdx <= maxidx;
      empty  <= 1'b0;
    end
  end

endmodule

// File: rtl/sfft_band_peak_finder.sv
// ---------------------------------------------------------------------------
// sfft_band_peak_finder
//   Snapshots the positive-frequency half of an SFFT output frame, scans it
//   one bin per clock and emits one peak record per band on a valid/ready
//   stream.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     SFFT_In         : NFFT signed bins, bin k at [k*DATA_WIDTH +: DATA_WIDTH]
//     InputValid      : one-cycle frame strobe
//     peak_valid/ready: record handshake
//     peak_bin        : absolute bin index of the band peak
//     peak_mag        : unsigned magnitude of the peak
//     peak_band       : band number
//     peak_frame      : frame id (mod 256, first frame after reset is 0)
//     peak_last       : record belongs to the last band
//     busy            : controller not idle
//     frames_dropped  : saturating count of frames ignored while busy
// ---------------------------------------------------------------------------
module sfft_band_peak_finder
  import sfft_peak_pkg::*;
#(
  parameter int unsigned NFFT           = 512,
  parameter int unsigned NFFT_LOG2      = 9,
  parameter int unsigned DATA_WIDTH     = 24,
  parameter int unsigned NUM_BANDS      = 8,
  parameter int unsigned SKIP_DC        = 1,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NFFT*DATA_WIDTH-1:0]           SFFT_In,
  input  logic                                 InputValid,
  output logic                                 peak_valid,
  input  logic                                 peak_ready,
  output logic [NFFT_LOG2-2:0]                 peak_bin,
  output logic [DATA_WIDTH-1:0]                peak_mag,
  output logic [bandIdxWidth(NUM_BANDS)-1:0]   peak_band,
  output logic [7:0]                           peak_frame,
  output logic                                 peak_last,
  output logic                                 busy,
  output logic [DROP_CNT_WIDTH-1:0]            frames_dropped
);

  localparam int unsigned HALF    = NFFT / 2;
  localparam int unsigned B       = binsPerBand(NFFT, NUM_BANDS);
  localparam int unsigned B_SHIFT = $clog2(B);
  localparam int unsigned BIN_W   = NFFT_LOG2 - 1;
  localparam int unsigned BAND_W  = bandIdxWidth(NUM_BANDS);
  localparam logic [BIN_W-1:0] B_MASK = BIN_W'(B - 1);

  peakState_e            state;
  logic [BIN_W-1:0]      idx;
  logic [7:0]            frameCnt;
  logic [7:0]            curFrame;
  logic [DATA_WIDTH-1:0] snap [HALF];

  logic                  frameAccept;
  logic                  frameDrop;
  logic                  lastBin;
  logic [BAND_W-1:0]     curBand;
  logic                  lastBand;
  logic                  scanEn;
  logic                  maxClear;
  logic [DATA_WIDTH-1:0] bandMax;
  logic [BIN_W-1:0]      bandMaxIdx;
  logic                  unusedUpperBins;

  // Only the positive-frequency half is ever looked at.
  assign unusedUpperBins = ^SFFT_In[NFFT*DATA_WIDTH-1:HALF*DATA_WIDTH];

  always_comb begin
    // A new frame may start from IDLE, or in the very cycle the last record
    // of the current frame is handed over (back-to-back restart).
    frameAccept = InputValid &&
                  ((state == IDLE) ||
                   ((state == EMIT) && peak_ready && peak_last));
    frameDrop   = InputValid && !frameAccept;
    lastBin     = (idx & B_MASK) == B_MASK;
    curBand     = BAND_W'(idx >> B_SHIFT);
    lastBand    = curBand == BAND_W'(NUM_BANDS - 1);
    scanEn      = (state == SCAN);
    // Clearing on the last bin seeds the next band while the current band's
    // result is still visible combinationally for capture.
    maxClear    = frameAccept || (scanEn && lastBin);
  end

  assign busy = (state != IDLE);

  // Snapshot storage has no reset; it is only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (frameAccept && !reset) begin
      for (int unsigned k = 0; k < HALF; k++) begin
        snap[k] <= SFFT_In[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  sfft_band_max #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (BIN_W),
    .SKIP_DC    (SKIP_DC)
  ) u_bandMax (
    .clk    (clk),
    .reset  (reset),
    .clear  (maxClear),
    .en     (scanEn),
    .sample (snap[idx]),
    .idx    (idx),
    .max    (bandMax),
    .maxidx (bandMaxIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      frameCnt       <= '0;
      curFrame       <= '0;
      frames_dropped <= '0;
      peak_valid     <= 1'b0;
      peak_last      <= 1'b0;
      peak_bin       <= '0;
      peak_mag       <= '0;
      peak_band      <= '0;
      peak_frame     <= '0;
    end else begin
      if (frameDrop && (frames_dropped != '1)) begin
        frames_dropped <= frames_dropped + DROP_CNT_WIDTH'(1);
      end
      if (frameAccept) begin
        curFrame <= frameCnt;
        frameCnt <= frameCnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (frameAccept) begin
            idx   <= '0;
            state <= SCAN;
          end
        end

        SCAN: begin
          // Wraps to 0 after the final bin of the last band.
          idx <= idx + BIN_W'(1);
          if (lastBin) begin
            peak_valid <= 1'b1;
            peak_bin   <= bandMaxIdx;
            peak_mag   <= bandMax;
            peak_band  <= curBand;
            peak_frame <= curFrame;
            peak_last  <= lastBand;
            state      <= EMIT;
          end
        end

        EMIT: begin
          if (peak_ready) begin
            peak_valid <= 1'b0;
            peak_last  <= 1'b0;
            if (!peak_last) begin
              state <= SCAN;
            end else if (frameAccept) begin
              idx   <= '0;
              state <= SCAN;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
